pwm_multicanal: RTL and testbench

- Parametrised successor to the single-channel PWM generator.
- Provides N independent PWM channels sharing one period counter.
- Each channel has an arbitrary W-bit duty, written at runtime through a write port.
- Period and mode (edge-/center-aligned) are runtime-programmable.
- All new values are double-buffered and take effect only at a period boundary, so no glitched or truncated pulses occur.
- Drives servo/actuator outputs and debug LEDs at the top level.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_contador.sv | 82 ++++++++
 rtl/pwm_multicanal.sv | 105 ++++++++++
 tb/tb_pwm_multicanal.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared encodings and helpers for the multi-channel PWM generator.
package pwm_pkg;

    localparam logic MODO_BORDA  = 1'b0;
    localparam logic MODO_CENTRO = 1'b1;

    typedef enum logic {
        DIR_SUBIDA  = 1'b0,
        DIR_DESCIDA = 1'b1
    } direcao_t;

    // Channel index width; a single channel still needs one select bit.
    function automatic int largura_indice(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_contador.sv
// Shared period counter: edge (sawtooth) or center (triangle) counting,
// boundary decode and the strobe that loads the active registers.
module pwm_contador
    import pwm_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] periodo_ativo,
    input  logic         modo_ativo,
    output logic [W-1:0] contagem,
    output logic         fim_c,
    output logic         carga_c
);

    direcao_t     direcao;
    direcao_t     direcao_prox;
    logic [W-1:0] contagem_prox;
    logic [W-1:0] p_ef;
    logic [W-1:0] p_m1;
    logic [W-1:0] p_m2;
    logic         fronteira;

    // Effective period is never below 2, so P-1 and P-2 cannot wrap.
    always_comb begin
        p_ef = (periodo_ativo < W'(2)) ? W'(2) : periodo_ativo;
        p_m1 = p_ef - W'(1);
        p_m2 = p_ef - W'(2);
    end

    always_comb begin
        fronteira     = 1'b0;
        contagem_prox = contagem + W'(1);
        direcao_prox  = direcao;
        if (modo_ativo == MODO_CENTRO) begin
            if (direcao == DIR_SUBIDA) begin
                if (contagem >= p_m1) begin
                    // With P=2 there is no descending leg: the top is the boundary.
                    if (p_m2 == '0) begin
                        fronteira     = 1'b1;
                        contagem_prox = '0;
                    end else begin
                        direcao_prox  = DIR_DESCIDA;
                        contagem_prox = p_m2;
                    end
                end
            end else begin
                if (contagem <= W'(1)) begin
                    fronteira     = 1'b1;
                    contagem_prox = '0;
                    direcao_prox  = DIR_SUBIDA;
                end else begin
                    contagem_prox = contagem - W'(1);
                end
            end
        end else begin
            if (contagem >= p_m1) begin
                fronteira     = 1'b1;
                contagem_prox = '0;
                direcao_prox  = DIR_SUBIDA;
            end
        end
        fim_c   = enable && fronteira;
        carga_c = fim_c || !enable;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            contagem <= '0;
            direcao  <= DIR_SUBIDA;
        end else if (!enable) begin
            contagem <= '0;
            direcao  <= DIR_SUBIDA;
        end else begin
            contagem <= contagem_prox;
            direcao  <= direcao_prox;
        end
    end

endmodule

// File: rtl/pwm_multicanal.sv
// N-channel PWM generator on one shared counter; duty, period and mode are
// double-buffered and only take effect at a period boundary.
module pwm_multicanal
    import pwm_pkg::*;
#(
    parameter int unsigned  N_CANAIS        = 4,
    parameter int unsigned  W               = 16,
    parameter int unsigned  PERIODO_DEFAULT = 1250,
    localparam int unsigned CW              = largura_indice(N_CANAIS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_canal,
    input  logic [W-1:0]        wr_dado,
    input  logic                per_en,
    input  logic [W-1:0]        periodo,
    input  logic                modo,
    output logic [N_CANAIS-1:0] pwm,
    output logic [N_CANAIS-1:0] db_pwm,
    output logic                fim_periodo,
    output logic [N_CANAIS-1:0] pendente
);

    logic [W-1:0]        contagem;
    logic                fim_c;
    logic                carga_c;
    logic [W-1:0]        per_sombra;
    logic [W-1:0]        periodo_ativo;
    logic                modo_ativo;
    logic [N_CANAIS-1:0] pwm_prox;
    logic [N_CANAIS-1:0] pend_prox;

    pwm_contador #(
        .W(W)
    ) u_contador (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .periodo_ativo (periodo_ativo),
        .modo_ativo    (modo_ativo),
        .contagem      (contagem),
        .fim_c         (fim_c),
        .carga_c       (carga_c)
    );

    // Period/mode buffers; a write coinciding with the load is forwarded.
    always_ff @(posedge clock) begin
        if (!reset) begin
            per_sombra    <= W'(PERIODO_DEFAULT);
            periodo_ativo <= W'(PERIODO_DEFAULT);
            modo_ativo    <= MODO_BORDA;
        end else begin
            if (per_en) begin
                per_sombra <= periodo;
            end
            if (carga_c) begin
                periodo_ativo <= per_en ? periodo : per_sombra;
                modo_ativo    <= modo;
            end
        end
    end

    for (genvar i = 0; i < int'(N_CANAIS); i++) begin : g_canal
        logic [W-1:0] sombra;
        logic [W-1:0] duty_ativo;
        logic         escrita;

        // Out-of-range indices never match, so such writes are dropped.
        assign escrita = wr_en && (wr_canal == CW'(i));

        always_ff @(posedge clock) begin
            if (!reset) begin
                sombra     <= '0;
                duty_ativo <= '0;
            end else begin
                if (escrita) begin
                    sombra <= wr_dado;
                end
                if (carga_c) begin
                    duty_ativo <= escrita ? wr_dado : sombra;
                end
            end
        end

        assign pwm_prox[i]  = enable && (contagem < duty_ativo);
        assign pend_prox[i] = carga_c ? 1'b0 : (escrita ? 1'b1 : pendente[i]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pwm         <= '0;
            fim_periodo <= 1'b0;
            pendente    <= '0;
        end else begin
            pwm         <= pwm_prox;
            fim_periodo <= fim_c;
            pendente    <= pend_prox;
        end
    end

    assign db_pwm = pwm;

endmodule

// File: tb/tb_pwm_multicanal.sv
// Scoreboard bench for pwm_multicanal with three channels.
module tb_pwm_multicanal;

    localparam int unsigned N  = 3;
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         wr_en;
    logic [CW-1:0] wr_canal;
    logic [W-1:0] wr_dado;
    logic         per_en;
    logic [W-1:0] periodo;
    logic         modo;
    logic [N-1:0] pwm;
    logic [N-1:0] db_pwm;
    logic         fim_periodo;
    logic [N-1:0] pendente;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0] pwm;
        logic       fim;
        logic [2:0] pend;
    } exp_t;

    exp_t sb[$];

    pwm_multicanal #(
        .N_CANAIS        (N),
        .W               (W),
        .PERIODO_DEFAULT (1250)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_canal    (wr_canal),
        .wr_dado     (wr_dado),
        .per_en      (per_en),
        .periodo     (periodo),
        .modo        (modo),
        .pwm         (pwm),
        .db_pwm      (db_pwm),
        .fim_periodo (fim_periodo),
        .pendente    (pendente)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Edge-mode expectation: output after tick j reflects count (j-1)%p.
    function automatic logic edge_on(input int j, input int p, input int d_old, input int d_new);
        return ((j - 1) % p) < ((((j - 1) / p) == 0) ? d_old : d_new);
    endfunction

    // Advance until the period-start pulse; leaves the counter at 0.
    task automatic wait_fim(input string nome);
        bit got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            tick();
            if (fim_periodo === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s sync: fim_periodo not seen within 100 clocks", nome);
        end
    endtask

    task automatic test_reset();
        exp_t e, r;
        reset = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_canal = '0; wr_dado = '0;
        per_en = 1'b0; periodo = '0; modo = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            if (j == 4) reset = 1'b1;
            per_en = (j == 6);
            periodo = 16'd10;
            e = '{pwm: 3'b000, fim: 1'b0, pend: 3'b000};
            sb.push_back(e);
            tick();
            r = sb.pop_front();
            n_checks++;
            if ({pwm, db_pwm, fim_periodo, pendente} !== {r.pwm, r.pwm, r.fim, r.pend}) begin
                n_fail++;
                $display("FAIL reset j=%0d pwm=%b db=%b fim=%b pend=%b expected pwm=%b fim=%b pend=%b",
                         j, pwm, db_pwm, fim_periodo, pendente, r.pwm, r.fim, r.pend);
            end
        end
        per_en = 1'b0;
        enable = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            e = '{pwm: 3'b000, fim: ((j % 10) == 0), pend: 3'b000};
            sb.push_back(e);
            tick();
            r = sb.pop_front();
            n_checks++;
            if ({pwm, db_pwm, fim_periodo, pendente} !== {r.pwm, r.pwm, r.fim, r.pend}) begin
                n_fail++;
                $display("FAIL idle_period j=%0d pwm=%b db=%b fim=%b pend=%b expected pwm=%b fim=%b pend=%b",
                         j, pwm, db_pwm, fim_periodo, pendente, r.pwm, r.fim, r.pend);
            end
        end
    endtask

    task automatic test_edge();
        exp_t e, r;
        wait_fim("edge");
        for (int j = 1; j <= 30; j++) begin
            wr_en = 1'b0;
            if (j == 1) begin wr_en = 1'b1; wr_canal = 2'd0; wr_dado = 16'd3; end
            if (j == 2) begin wr_en = 1'b1; wr_canal = 2'd1; wr_dado = 16'd10; end
            e.pwm[0] = edge_on(j, 10, 0, 3);
            e.pwm[1] = edge_on(j, 10, 0, 10);
            e.pwm[2] = 1'b0;
            e.fim    = ((j % 10) == 0);
            e.pend   = (j == 1) ? 3'b001 : ((j <= 9) ? 3'b011 : 3'b000);
            sb.push_back(e);
            tick();
            r = sb.pop_front();
            n_checks++;
            if ({pwm, db_pwm, fim_periodo, pendente} !== {r.pwm, r.pwm, r.fim, r.pend}) begin
                n_fail++;
                $display("FAIL edge j=%0d pwm=%b db=%b fim=%b pend=%b expected pwm=%b fim=%b pend=%b",
                         j, pwm, db_pwm, fim_periodo, pendente, r.pwm, r.fim, r.pend);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_shadow();
        exp_t e, r;
        wait_fim("shadow");
        for (int j = 1; j <= 30; j++) begin
            wr_en = 1'b0;
            if (j == 5) begin wr_en = 1'b1; wr_canal = 2'd0; wr_dado = 16'd7; end
            e.pwm  = {1'b0, 1'b1, edge_on(j, 10, 3, 7)};
            e.fim  = ((j % 10) == 0);
            e.pend = (j >= 5 && j <= 9) ? 3'b001 : 3'b000;
            sb.push_back(e);
            tick();
            r = sb.pop_front();
            n_checks++;
            if ({pwm, db_pwm, fim_periodo, pendente} !== {r.pwm, r.pwm, r.fim, r.pend}) begin
                n_fail++;
                $display("FAIL shadow j=%0d pwm=%b db=%b fim=%b pend=%b expected pwm=%b fim=%b pend=%b",
                         j, pwm, db_pwm, fim_periodo, pendente, r.pwm, r.fim, r.pend);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e, r;
        wait_fim("collision");
        for (int j = 1; j <= 20; j++) begin
            wr_en = 1'b0;
            if (j == 10) begin wr_en = 1'b1; wr_canal = 2'd0; wr_dado = 16'd5; end
            e.pwm  = {1'b0, 1'b1, edge_on(j, 10, 7, 5)};
            e.fim  = ((j % 10) == 0);
            e.pend = 3'b000;
            sb.push_back(e);
            tick();
            r = sb.pop_front();
            n_checks++;
            if ({pwm, db_pwm, fim_periodo, pendente} !== {r.pwm, r.pwm, r.fim, r.pend}) begin
                n_fail++;
                $display("FAIL collision j=%0d pwm=%b db=%b fim=%b pend=%b expected pwm=%b fim=%b pend=%b",
                         j, pwm, db_pwm, fim_periodo, pendente, r.pwm, r.fim, r.pend);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_center();
        exp_t e, r;
        int   q, c;
        wait_fim("center");
        modo = 1'b1;
        for (int j = 1; j <= 64; j++) begin
            wr_en = 1'b0;
            if (j == 2) begin wr_en = 1'b1; wr_canal = 2'd0; wr_dado = 16'd3; end
            if (j <= 10) begin
                e.pwm[0] = ((j - 1) < 5);
                e.pwm[1] = 1'b1;
            end else begin
                q = (j - 11) % 18;
                c = (q <= 9) ? q : 18 - q;
                e.pwm[0] = (c < 3);
                e.pwm[1] = (c < 10);
            end
            e.pwm[2] = 1'b0;
            e.fim    = (j >= 10) && (((j - 10) % 18) == 0);
            e.pend   = (j >= 2 && j <= 9) ? 3'b001 : 3'b000;
            sb.push_back(e);
            tick();
            r = sb.pop_front();
            n_checks++;
            if ({pwm, db_pwm, fim_periodo, pendente} !== {r.pwm, r.pwm, r.fim, r.pend}) begin
                n_fail++;
                $display("FAIL center j=%0d pwm=%b db=%b fim=%b pend=%b expected pwm=%b fim=%b pend=%b",
                         j, pwm, db_pwm, fim_periodo, pendente, r.pwm, r.fim, r.pend);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_periodo_zero();
        exp_t e, r;
        int   q, c;
        wait_fim("periodo_zero");
        modo = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            wr_en  = 1'b0;
            per_en = 1'b0;
            if (j == 1) begin
                per_en = 1'b1; periodo = 16'd0;
                wr_en = 1'b1; wr_canal = 2'd2; wr_dado = 16'd1;
            end
            if (j <= 18) begin
                q = (j - 1) % 18;
                c = (q <= 9) ? q : 18 - q;
                e.pwm = {1'b0, 1'b1, logic'(c < 3)};
            end else begin
                e.pwm = {logic'((j % 2) == 1), 1'b1, 1'b1};
            end
            e.fim  = (j >= 18) && ((j % 2) == 0);
            e.pend = (j <= 17) ? 3'b100 : 3'b000;
            sb.push_back(e);
            tick();
            r = sb.pop_front();
            n_checks++;
            if ({pwm, db_pwm, fim_periodo, pendente} !== {r.pwm, r.pwm, r.fim, r.pend}) begin
                n_fail++;
                $display("FAIL periodo_zero j=%0d pwm=%b db=%b fim=%b pend=%b expected pwm=%b fim=%b pend=%b",
                         j, pwm, db_pwm, fim_periodo, pendente, r.pwm, r.fim, r.pend);
            end
        end
        wr_en = 1'b0; per_en = 1'b0;
    endtask

    task automatic test_bad_channel();
        exp_t e, r;
        wait_fim("bad_channel");
        for (int j = 1; j <= 10; j++) begin
            wr_en = 1'b0;
            if (j == 1) begin wr_en = 1'b1; wr_canal = 2'd3; wr_dado = 16'd0; end
            e.pwm  = {logic'((j % 2) == 1), 1'b1, 1'b1};
            e.fim  = ((j % 2) == 0);
            e.pend = 3'b000;
            sb.push_back(e);
            tick();
            r = sb.pop_front();
            n_checks++;
            if ({pwm, db_pwm, fim_periodo, pendente} !== {r.pwm, r.pwm, r.fim, r.pend}) begin
                n_fail++;
                $display("FAIL bad_channel j=%0d pwm=%b db=%b fim=%b pend=%b expected pwm=%b fim=%b pend=%b",
                         j, pwm, db_pwm, fim_periodo, pendente, r.pwm, r.fim, r.pend);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e, r;
        wait_fim("reset_mid");
        for (int j = 1; j <= 30; j++) begin
            wr_en  = 1'b0;
            per_en = 1'b0;
            reset  = 1'b1;
            if (j == 1) begin per_en = 1'b1; periodo = 16'd10; end
            if (j == 9) begin
                reset = 1'b0;
                wr_en = 1'b1; wr_canal = 2'd0; wr_dado = 16'd8;
            end
            if (j == 10) begin
                enable = 1'b0;
                per_en = 1'b1; periodo = 16'd10;
                wr_en = 1'b1; wr_canal = 2'd0; wr_dado = 16'd3;
            end
            if (j >= 11) enable = 1'b1;
            case (j)
                1, 3:       e.pwm = 3'b111;
                2, 4, 5:    e.pwm = 3'b011;
                6, 7, 8:    e.pwm = 3'b010;
                11, 12, 13,
                21, 22, 23: e.pwm = 3'b001;
                default:    e.pwm = 3'b000;
            endcase
            e.fim  = (j == 2) || (j == 20) || (j == 30);
            e.pend = 3'b000;
            sb.push_back(e);
            tick();
            r = sb.pop_front();
            n_checks++;
            if ({pwm, db_pwm, fim_periodo, pendente} !== {r.pwm, r.pwm, r.fim, r.pend}) begin
                n_fail++;
                $display("FAIL reset_mid j=%0d pwm=%b db=%b fim=%b pend=%b expected pwm=%b fim=%b pend=%b",
                         j, pwm, db_pwm, fim_periodo, pendente, r.pwm, r.fim, r.pend);
            end
        end
        wr_en = 1'b0; per_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge();
        test_shadow();
        test_back_to_back();
        test_center();
        test_periodo_zero();
        test_bad_channel();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
